fp_adder_pipe: RTL
==================

# fp_adder_pipe

- Three-stage pipelined IEEE-754 single-precision adder.
- Sits directly downstream of the operand data memory and consumes its `out_a`/`out_b` pair.
- Produces a rounded sum plus exception flags, with a valid qualifier.
- Round-to-nearest-even; denormal inputs and results are flushed to zero. One operation accepted per cycle.

## Interface
- No parameters. Latency fixed at 3 cycles.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: `a`/`b` are sampled this cycle.
- `a` in 32: operand A, IEEE-754 binary32.
- `b` in 32: operand B, IEEE-754 binary32.
- `out_valid` out 1: `result`/flags valid this cycle.
- `result` out 32: A+B, binary32.
- `ovf` out 1: finite operands produced ±Inf.
- `udf` out 1: a nonzero exact result was flushed to signed zero.
- `nv` out 1: invalid operation; canonical NaN returned.
- `nx` out 1: the result is inexact (round, sticky, overflow or flush).

## Operation
- **Stage 1 (unpack/compare):**
  - Split sign, 8-bit exponent, 23-bit fraction, and append the hidden 1.
  - Exponent 0 means the operand is treated as zero of its sign (FTZ).
  - Classify each operand: zero, normal, Inf, NaN.
  - Swap operands so |big| ≥ |small|, comparing {exp, frac}.
  - Register the exponent difference `d` (8 bits, unsigned).
  - Register `eff_sub` = sign_a XOR sign_b, and the special-case code.
- **Stage 2 (align/add):**
  - Shift the small 24-bit mantissa right by min(d, 27) into a 27-bit field (24 + guard, round, sticky).
  - Sticky is the OR of every bit shifted out.
  - When `eff_sub` = 1, compute big − small; otherwise compute big + small.
  - Result is 28 bits, carry included. Sign = sign of big.
- **Stage 3 (normalize/round/pack):**
  - Carry set: shift right 1 (fold into sticky), exp+1.
  - Otherwise: leading-zero count (0..26), shift left, exp − lzc.
  - RNE: increment when G && (R || S || LSB). If the mantissa overflows after rounding, exp+1.
  - Exponent ≥ 255 → ±Inf, `ovf`=1, `nx`=1.
  - Exponent ≤ 0 with nonzero magnitude → ±0, `udf`=1, `nx`=1.
- **Special-case priority (overrides the arithmetic):**
  - Any NaN input → 0x7FC00000. `nv`=1 only if a signalling NaN was present (frac MSB = 0).
  - +Inf + −Inf → 0x7FC00000, `nv`=1.
  - Inf + anything else → that Inf, no flags.
  - Exact-zero sum of opposite signs → +0.
  - Zero + zero → sign is the AND of the two signs.
- Flags are meaningful only when `out_valid`=1 and are held at 0 otherwise.

## Timing
- Sample at edge N with `in_valid`=1; `out_valid`=1 with the matching result during cycle N+3.
- Throughput 1/cycle. No backpressure; the consumer must accept every `out_valid` beat.
- The valid bit travels with the data through 3 registered stages. Bubbles (`in_valid`=0) propagate as `out_valid`=0.
- Data registers may hold stale values in bubble cycles. `result` and flags are forced to 0 when the output valid is 0.
- **Reset:**
  - Asserting `rst_n`=0 immediately clears all stage valids, `out_valid`, `result` (0x00000000) and all flags.
  - An in-flight operation is discarded, not completed.
  - The first input sampled after deassertion appears 3 cycles later.

## Structure
- Shared package `fp_pkg`:
  - field widths (EXP_W=8, FRAC_W=23, BIAS=127);
  - class enum (ZERO, NORM, INF, NAN);
  - constants QNAN=32'h7FC00000, POS_INF, NEG_INF.
- One sub-module `fp_lzc28`: combinational leading-zero counter, 28-bit in, 5-bit count, instanced in stage 3.
- Everything else is inline in `fp_adder_pipe`.

## Test plan
- a=3F800000, b=40000000, single valid → cycle 3: `result`=40400000, all flags 0.
- Back-to-back: BF800000+3F800000 then C2DE8000+45155E00 → 00000000 (+0), then 450E6A00 on consecutive cycles.
- 7F7FFFFF+7F7FFFFF → 7F800000, `ovf`=1, `nx`=1. 00400000+3F800000 (denormal FTZ) → 3F800000, flags 0.
- 7F800000+FF800000 → 7FC00000, `nv`=1. 7FC00001+3F800000 → 7FC00000, `nv`=0. 7F800000+3F800000 → 7F800000.
- RNE tie: 4B800000+3F800000 (2^24+1) → 4B800000, `nx`=1. 4B800001+3F800000 → 4B800002, `nx`=1.
- Three valids in flight, `rst_n` pulsed low mid-stream → `out_valid`/`result`/flags 0 immediately, and no stale outputs after release.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared definitions for the pipelined binary32 adder: field widths, operand
// classes, special-case codes, canonical encodings and the stage register layouts.
package fp_pkg;

   localparam int EXP_W   = 8;
   localparam int FRAC_W  = 23;
   localparam int BIAS    = 127;
   localparam int MANT_W  = FRAC_W + 1;
   localparam int EXP_MAX = 2 * BIAS + 1;

   localparam logic [31:0] QNAN    = 32'h7FC0_0000;
   localparam logic [31:0] POS_INF = 32'h7F80_0000;
   localparam logic [31:0] NEG_INF = 32'hFF80_0000;

   typedef enum logic [1:0] {
      CLS_ZERO,
      CLS_NORM,
      CLS_INF,
      CLS_NAN
   } fp_class_e;

   typedef enum logic [1:0] {
      SP_NONE,
      SP_NAN,
      SP_INF,
      SP_ZERO
   } special_e;

   // Stage 1 -> stage 2: operands ordered by magnitude plus the override decision.
   typedef struct packed {
      logic                sign;
      logic [EXP_W-1:0]    exp;
      logic [MANT_W-1:0]   mant_big;
      logic [MANT_W-1:0]   mant_small;
      logic [EXP_W-1:0]    d;
      logic                eff_sub;
      special_e            sp;
      logic                sp_sign;
      logic                sp_nv;
   } s1_t;

   typedef struct packed {
      logic                sign;
      logic [EXP_W-1:0]    exp;
      logic [27:0]         sum;
      special_e            sp;
      logic                sp_sign;
      logic                sp_nv;
   } s2_t;

   // Exponent 0 is flushed to zero regardless of fraction.
   function automatic fp_class_e classify(input logic [EXP_W-1:0]  e,
                                          input logic [FRAC_W-1:0] f);
      if (e == '0)
         return CLS_ZERO;
      else if (e == '1)
         return (f == '0) ? CLS_INF : CLS_NAN;
      else
         return CLS_NORM;
   endfunction

endpackage

// File: rtl/fp_lzc28.sv
// Combinational leading-zero counter: 28-bit input, count 0..28 (28 for all zeros).
module fp_lzc28 (
   input  logic [27:0] din,
   output logic [4:0]  count
);

   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no
      // path leaves it unassigned and no latch is inferred.
      count = 5'd28;
      for (int i = 0; i < 28; i++) begin
         if (din[i]) count = 5'(27 - i);
      end
   end

endmodule

// File: rtl/fp_adder_pipe.sv
// Three-stage binary32 adder: unpack/compare, align/add, normalize/round/pack.
// RNE rounding, FTZ on inputs and results, valid travels with the data.
module fp_adder_pipe
   import fp_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        out_valid,
   output logic [31:0] result,
   output logic        ovf,
   output logic        udf,
   output logic        nv,
   output logic        nx
);

   logic        s1_valid_d, s1_valid_q;
   logic        s2_valid_d, s2_valid_q;
   logic        out_valid_d, out_valid_q;
   s1_t         s1_d, s1_q;
   s2_t         s2_d, s2_q;
   logic [31:0] result_d, result_q;
   logic        ovf_d, ovf_q, udf_d, udf_q, nv_d, nv_q, nx_d, nx_q;

   // ---------------- Stage 1: unpack / classify / order ----------------
   logic              sa, sb, a_big, snan_a, snan_b;
   logic [EXP_W-1:0]  ea, eb;
   logic [FRAC_W-1:0] fa, fb;
   logic [30:0]       key_a, key_b;
   logic [MANT_W-1:0] mant_a, mant_b;
   fp_class_e         ca, cb;

   always_comb begin
      sa     = a[31];
      sb     = b[31];
      ea     = a[30:23];
      eb     = b[30:23];
      fa     = a[22:0];
      fb     = b[22:0];
      ca     = classify(ea, fa);
      cb     = classify(eb, fb);
      key_a  = (ea == '0) ? '0 : a[30:0];
      key_b  = (eb == '0) ? '0 : b[30:0];
      mant_a = (ea == '0) ? '0 : {1'b1, fa};
      mant_b = (eb == '0) ? '0 : {1'b1, fb};
      a_big  = (key_a >= key_b);
      snan_a = (ca == CLS_NAN) && !fa[FRAC_W-1];
      snan_b = (cb == CLS_NAN) && !fb[FRAC_W-1];

      s1_d            = '0;
      s1_d.sign       = a_big ? sa : sb;
      s1_d.exp        = a_big ? ea : eb;
      s1_d.mant_big   = a_big ? mant_a : mant_b;
      s1_d.mant_small = a_big ? mant_b : mant_a;
      s1_d.d          = a_big ? (ea - eb) : (eb - ea);
      s1_d.eff_sub    = sa ^ sb;
      s1_d.sp         = SP_NONE;

      if (ca == CLS_NAN || cb == CLS_NAN) begin
         s1_d.sp    = SP_NAN;
         s1_d.sp_nv = snan_a | snan_b;
      end else if (ca == CLS_INF && cb == CLS_INF && sa != sb) begin
         s1_d.sp    = SP_NAN;
         s1_d.sp_nv = 1'b1;
      end else if (ca == CLS_INF) begin
         s1_d.sp      = SP_INF;
         s1_d.sp_sign = sa;
      end else if (cb == CLS_INF) begin
         s1_d.sp      = SP_INF;
         s1_d.sp_sign = sb;
      end else if (ca == CLS_ZERO && cb == CLS_ZERO) begin
         s1_d.sp      = SP_ZERO;
         s1_d.sp_sign = sa & sb;
      end
   end

   // ---------------- Stage 2: align / add ----------------
   logic [4:0]  shamt;
   logic [26:0] small_ext, big_ext, shifted, lost_mask, aligned;
   logic        sticky;

   always_comb begin
      shamt     = (s1_q.d > 8'd27) ? 5'd27 : s1_q.d[4:0];
      small_ext = {s1_q.mant_small, 3'b000};
      big_ext   = {s1_q.mant_big, 3'b000};
      shifted   = small_ext >> shamt;
      lost_mask = 27'((28'd1 << shamt) - 28'd1);
      sticky    = |(small_ext & lost_mask);
      aligned   = {shifted[26:1], shifted[0] | sticky};

      s2_d         = '0;
      s2_d.sign    = s1_q.sign;
      s2_d.exp     = s1_q.exp;
      s2_d.sum     = s1_q.eff_sub ? ({1'b0, big_ext} - {1'b0, aligned})
                                  : ({1'b0, big_ext} + {1'b0, aligned});
      s2_d.sp      = s1_q.sp;
      s2_d.sp_sign = s1_q.sp_sign;
      s2_d.sp_nv   = s1_q.sp_nv;
   end

   // ---------------- Stage 3: normalize / round / pack ----------------
   logic [4:0]         lz28, lz;
   logic [26:0]        norm;
   logic signed [9:0]  exp_n, exp_r;
   logic               round_inc, inexact;
   logic [24:0]        rounded;
   logic [FRAC_W-1:0]  frac_r;

   fp_lzc28 u_lzc (
      .din   (s2_q.sum),
      .count (lz28)
   );

   always_comb begin
      // Bit 27 is clear on this path, so the 27-bit field has one less leading zero.
      lz = lz28 - 5'd1;
      if (s2_q.sum[27]) begin
         norm  = {s2_q.sum[27:2], |s2_q.sum[1:0]};
         exp_n = $signed({2'b00, s2_q.exp}) + 10'sd1;
      end else begin
         norm  = s2_q.sum[26:0] << lz;
         exp_n = $signed({2'b00, s2_q.exp}) - $signed({5'b00000, lz});
      end

      round_inc = norm[2] & (norm[1] | norm[0] | norm[3]);
      inexact   = |norm[2:0];
      rounded   = {1'b0, norm[26:3]} + {24'd0, round_inc};
      if (rounded[24]) begin
         frac_r = rounded[23:1];
         exp_r  = exp_n + 10'sd1;
      end else begin
         frac_r = rounded[22:0];
         exp_r  = exp_n;
      end

      result_d    = '0;
      ovf_d       = 1'b0;
      udf_d       = 1'b0;
      nv_d        = 1'b0;
      nx_d        = 1'b0;
      out_valid_d = s2_valid_q;

      if (s2_valid_q) begin
         unique case (s2_q.sp)
            SP_NAN: begin
               result_d = QNAN;
               nv_d     = s2_q.sp_nv;
            end
            SP_INF:  result_d = s2_q.sp_sign ? NEG_INF : POS_INF;
            SP_ZERO: result_d = {s2_q.sp_sign, 31'd0};
            default: begin
               if (s2_q.sum == '0) begin
                  result_d = '0;
               end else if (int'(exp_r) >= EXP_MAX) begin
                  result_d = s2_q.sign ? NEG_INF : POS_INF;
                  ovf_d    = 1'b1;
                  nx_d     = 1'b1;
               end else if (int'(exp_r) <= 0) begin
                  result_d = {s2_q.sign, 31'd0};
                  udf_d    = 1'b1;
                  nx_d     = 1'b1;
               end else begin
                  result_d = {s2_q.sign, exp_r[7:0], frac_r};
                  nx_d     = inexact;
               end
            end
         endcase
      end
   end

   assign s1_valid_d = in_valid;
   assign s2_valid_d = s1_valid_q;

   // NOTE: sequential state is written only with <= so every flop samples the
   // pre-edge values; combinational blocks above use = for in-order evaluation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s2_valid_q  <= 1'b0;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         ovf_q       <= 1'b0;
         udf_q       <= 1'b0;
         nv_q        <= 1'b0;
         nx_q        <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s2_valid_q  <= s2_valid_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         ovf_q       <= ovf_d;
         udf_q       <= udf_d;
         nv_q        <= nv_d;
         nx_q        <= nx_d;
      end
   end

   // NOTE: wide data stage registers carry no reset; the stage valids qualify
   // them, so stale contents after reset are never observed.
   always_ff @(posedge clk) begin
      s1_q <= s1_d;
      s2_q <= s2_d;
   end

   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign ovf       = ovf_q;
   assign udf       = udf_q;
   assign nv        = nv_q;
   assign nx        = nx_q;

endmodule
